// File: rtl/tl_d_channel_arbiter.sv
// Round-robin merge of N TileLink D-channel response streams onto one D port.
// Multi-beat data responses keep the grant until their last beat; a stalled grant never moves.
module tl_d_channel_arbiter #(
    parameter int N          = 2,
    parameter int BEAT_BYTES = 8,
    parameter int DATA_W     = 64,
    parameter int SIZE_W     = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N-1:0]            io_in_valid,
    output logic [N-1:0]            io_in_ready,
    input  logic [3*N-1:0]          io_in_bits_opcode,
    input  logic [2*N-1:0]          io_in_bits_param,
    input  logic [SIZE_W*N-1:0]     io_in_bits_size,
    input  logic [5*N-1:0]          io_in_bits_source,
    input  logic [3*N-1:0]          io_in_bits_sink,
    input  logic [N-1:0]            io_in_bits_denied,
    input  logic [DATA_W*N-1:0]     io_in_bits_data,
    input  logic [N-1:0]            io_in_bits_corrupt,
    input  logic                    io_out_ready,
    output logic                    io_out_valid,
    output logic [2:0]              io_out_bits_opcode,
    output logic [1:0]              io_out_bits_param,
    output logic [SIZE_W-1:0]       io_out_bits_size,
    output logic [4:0]              io_out_bits_source,
    output logic [2:0]              io_out_bits_sink,
    output logic                    io_out_bits_denied,
    output logic [DATA_W-1:0]       io_out_bits_data,
    output logic                    io_out_bits_corrupt,
    output logic [$clog2(N)-1:0]    io_grant_idx,
    output logic                    io_locked
);

    localparam int IDX_W  = $clog2(N);
    localparam int LOG_BB = $clog2(BEAT_BYTES);
    localparam int BL_RAW = (1 << SIZE_W) - LOG_BB;
    localparam int BL_W   = (BL_RAW > 8) ? 8 : ((BL_RAW < 1) ? 1 : BL_RAW);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BL_W-1:0]  beats_left_q, beats_left_d;
    logic             locked_q, locked_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             hold_valid_q, hold_valid_d;
    logic [IDX_W-1:0] hold_idx_q, hold_idx_d;

    logic [IDX_W-1:0] scan_idx;
    logic             scan_hit;
    logic [IDX_W-1:0] grant;
    logic             cand;
    logic             out_valid_raw;
    logic             fire;
    logic             has_data;
    logic [BL_W-1:0]  beats;
    int               j;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = rr_ptr_q;
        j        = 0;
        for (int k = 1; k <= N; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N) j = j - N;
            if (!scan_hit && io_in_valid[j]) begin
                scan_hit = 1'b1;
                scan_idx = IDX_W'(j);
            end
        end
    end

    always_comb begin
        grant = scan_idx;
        cand  = scan_hit;
        if (locked_q) begin
            grant = lock_idx_q;
            cand  = 1'b1;
        end else if (hold_valid_q) begin
            grant = hold_idx_q;
            cand  = 1'b1;
        end
    end

    assign out_valid_raw = cand & io_in_valid[grant];
    assign io_out_valid  = ~reset & out_valid_raw;
    assign fire          = io_out_valid & io_out_ready;
    assign io_grant_idx  = reset ? '0 : grant;
    assign io_locked     = ~reset & locked_q;

    always_comb begin
        io_in_ready = '0;
        if (!reset && io_out_ready) io_in_ready[grant] = 1'b1;
    end

    assign io_out_bits_opcode  = io_in_bits_opcode[int'(grant)*3 +: 3];
    assign io_out_bits_param   = io_in_bits_param[int'(grant)*2 +: 2];
    assign io_out_bits_size    = io_in_bits_size[int'(grant)*SIZE_W +: SIZE_W];
    assign io_out_bits_source  = io_in_bits_source[int'(grant)*5 +: 5];
    assign io_out_bits_sink    = io_in_bits_sink[int'(grant)*3 +: 3];
    assign io_out_bits_denied  = io_in_bits_denied[grant];
    assign io_out_bits_data    = io_in_bits_data[int'(grant)*DATA_W +: DATA_W];
    assign io_out_bits_corrupt = io_in_bits_corrupt[grant];

    // Bursts longer than the counter can hold saturate at its maximum.
    assign has_data = (io_out_bits_opcode == 3'd1) || (io_out_bits_opcode == 3'd5);
    always_comb begin
        beats = BL_W'(1);
        if (has_data && int'(io_out_bits_size) > LOG_BB) begin
            if (int'(io_out_bits_size) - LOG_BB >= BL_W) beats = '1;
            else beats = BL_W'(1) << (int'(io_out_bits_size) - LOG_BB);
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        beats_left_d = beats_left_q;
        locked_d     = locked_q;
        lock_idx_d   = lock_idx_q;
        hold_valid_d = hold_valid_q;
        hold_idx_d   = hold_idx_q;

        if (fire) begin
            hold_valid_d = 1'b0;
        end else if (!locked_q && io_out_valid && !io_out_ready) begin
            hold_valid_d = 1'b1;
            hold_idx_d   = grant;
        end

        if (fire && !locked_q) begin
            rr_ptr_d = grant;
            if (beats > BL_W'(1)) begin
                locked_d     = 1'b1;
                beats_left_d = beats - BL_W'(1);
                lock_idx_d   = grant;
            end
        end else if (fire && locked_q) begin
            if (beats_left_q == BL_W'(1)) begin
                locked_d     = 1'b0;
                beats_left_d = '0;
            end else begin
                beats_left_d = beats_left_q - BL_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q     <= IDX_W'(N - 1);
            beats_left_q <= '0;
            locked_q     <= 1'b0;
            lock_idx_q   <= '0;
            hold_valid_q <= 1'b0;
            hold_idx_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            beats_left_q <= beats_left_d;
            locked_q     <= locked_d;
            lock_idx_q   <= lock_idx_d;
            hold_valid_q <= hold_valid_d;
            hold_idx_q   <= hold_idx_d;
        end
    end

endmodule

// File: tb/tb_tl_d_channel_arbiter.sv
// Bench for tl_d_channel_arbiter: directed scenarios, a queue/int-level reference model
// compared every cycle, and literal fire-order expectations that pin the model.
module tb_tl_d_channel_arbiter;

    localparam int N  = 2;
    localparam int N3 = 3;
    localparam int SW = 4;
    localparam int DW = 64;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Stimulus for the N=2 instance
    logic [N-1:0]    in_valid;
    logic [2:0]      op [N];
    logic [SW-1:0]   sz [N];
    logic            out_ready;

    logic [3*N-1:0]  f_op;
    logic [2*N-1:0]  f_param;
    logic [SW*N-1:0] f_size;
    logic [5*N-1:0]  f_source;
    logic [3*N-1:0]  f_sink;
    logic [N-1:0]    f_denied;
    logic [DW*N-1:0] f_data;
    logic [N-1:0]    f_corrupt;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            f_op[3*i +: 3]     = op[i];
            f_param[2*i +: 2]  = 2'(i + 1);
            f_size[SW*i +: SW] = sz[i];
            f_source[5*i +: 5] = 5'(i + 9);
            f_sink[3*i +: 3]   = 3'(i + 3);
            f_denied[i]        = (i == 1);
            f_data[DW*i +: DW] = {16'(16'h1111 * (i + 1)), 48'(i + 5)};
            f_corrupt[i]       = (i == 0);
        end
    end

    logic [N-1:0]         in_ready;
    logic                 o_valid;
    logic [2:0]           o_opcode;
    logic [1:0]           o_param;
    logic [SW-1:0]        o_size;
    logic [4:0]           o_source;
    logic [2:0]           o_sink;
    logic                 o_denied;
    logic [DW-1:0]        o_data;
    logic                 o_corrupt;
    logic [$clog2(N)-1:0] o_grant;
    logic                 o_locked;

    tl_d_channel_arbiter #(.N(N), .BEAT_BYTES(8), .DATA_W(DW), .SIZE_W(SW)) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_bits_opcode(f_op), .io_in_bits_param(f_param), .io_in_bits_size(f_size),
        .io_in_bits_source(f_source), .io_in_bits_sink(f_sink), .io_in_bits_denied(f_denied),
        .io_in_bits_data(f_data), .io_in_bits_corrupt(f_corrupt),
        .io_out_ready(out_ready), .io_out_valid(o_valid),
        .io_out_bits_opcode(o_opcode), .io_out_bits_param(o_param), .io_out_bits_size(o_size),
        .io_out_bits_source(o_source), .io_out_bits_sink(o_sink), .io_out_bits_denied(o_denied),
        .io_out_bits_data(o_data), .io_out_bits_corrupt(o_corrupt),
        .io_grant_idx(o_grant), .io_locked(o_locked)
    );

    // Three-input instance for the rotation check
    logic [N3-1:0]         v3;
    logic                  ready3;
    logic [3*N3-1:0]       op3 = '0;
    logic [2*N3-1:0]       param3 = '0;
    logic [SW*N3-1:0]      size3 = '0;
    logic [5*N3-1:0]       source3 = '0;
    logic [3*N3-1:0]       sink3 = '0;
    logic [N3-1:0]         denied3 = '0;
    logic [DW*N3-1:0]      data3 = '0;
    logic [N3-1:0]         corrupt3 = '0;
    logic [N3-1:0]         in_ready3;
    logic                  o3_valid;
    logic [2:0]            o3_opcode;
    logic [1:0]            o3_param;
    logic [SW-1:0]         o3_size;
    logic [4:0]            o3_source;
    logic [2:0]            o3_sink;
    logic                  o3_denied;
    logic [DW-1:0]         o3_data;
    logic                  o3_corrupt;
    logic [$clog2(N3)-1:0] o3_grant;
    logic                  o3_locked;

    tl_d_channel_arbiter #(.N(N3), .BEAT_BYTES(8), .DATA_W(DW), .SIZE_W(SW)) dut3 (
        .clock(clock), .reset(reset),
        .io_in_valid(v3), .io_in_ready(in_ready3),
        .io_in_bits_opcode(op3), .io_in_bits_param(param3), .io_in_bits_size(size3),
        .io_in_bits_source(source3), .io_in_bits_sink(sink3), .io_in_bits_denied(denied3),
        .io_in_bits_data(data3), .io_in_bits_corrupt(corrupt3),
        .io_out_ready(ready3), .io_out_valid(o3_valid),
        .io_out_bits_opcode(o3_opcode), .io_out_bits_param(o3_param), .io_out_bits_size(o3_size),
        .io_out_bits_source(o3_source), .io_out_bits_sink(o3_sink), .io_out_bits_denied(o3_denied),
        .io_out_bits_data(o3_data), .io_out_bits_corrupt(o3_corrupt),
        .io_grant_idx(o3_grant), .io_locked(o3_locked)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: last winner, burst owner with beats remaining, and held stall index.
    int m_rr   = N - 1;
    int m_lock = -1;
    int m_left = 0;
    int m_hold = -1;
    int fire_log[$];
    int exp_log[$];

    function automatic int msg_beats(input int opcode, input int size);
        int b;
        if (opcode == 1 || opcode == 5) begin
            b = (1 << size) / 8;
            return (b < 1) ? 1 : b;
        end
        return 1;
    endfunction

    always @(negedge clock) begin
        int  g;
        bit  cand;
        bit  ev;
        if (reset) begin
            check("rst_out_valid", 64'(o_valid), 64'(0));
            check("rst_in_ready", 64'(in_ready), 64'(0));
            check("rst_grant", 64'(o_grant), 64'(0));
            check("rst_locked", 64'(o_locked), 64'(0));
            m_rr = N - 1; m_lock = -1; m_left = 0; m_hold = -1;
        end else begin
            cand = 1'b0;
            g    = m_rr;
            if (m_lock >= 0) begin
                g = m_lock; cand = 1'b1;
            end else if (m_hold >= 0) begin
                g = m_hold; cand = 1'b1;
            end else begin
                for (int k = 1; k <= N; k++)
                    if (!cand && in_valid[(m_rr + k) % N]) begin
                        cand = 1'b1; g = (m_rr + k) % N;
                    end
            end
            ev = cand && in_valid[g];
            check("out_valid", 64'(o_valid), 64'(ev));
            check("grant_idx", 64'(o_grant), 64'(g));
            check("in_ready", 64'(in_ready), out_ready ? (64'(1) << g) : 64'(0));
            check("locked", 64'(o_locked), 64'(m_lock >= 0));
            if (ev) begin
                check("out_opcode", 64'(o_opcode), 64'(op[g]));
                check("out_param", 64'(o_param), 64'(g + 1));
                check("out_size", 64'(o_size), 64'(sz[g]));
                check("out_source", 64'(o_source), 64'(g + 9));
                check("out_sink", 64'(o_sink), 64'(g + 3));
                check("out_denied", 64'(o_denied), 64'(g == 1));
                check("out_data", o_data, {16'(16'h1111 * (g + 1)), 48'(g + 5)});
                check("out_corrupt", 64'(o_corrupt), 64'(g == 0));
            end
            if (ev && out_ready) begin
                fire_log.push_back(g);
                m_hold = -1;
                if (m_lock < 0) begin
                    m_rr = g;
                    if (msg_beats(int'(op[g]), int'(sz[g])) > 1) begin
                        m_lock = g;
                        m_left = msg_beats(int'(op[g]), int'(sz[g])) - 1;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) m_lock = -1;
                end
            end else if (m_lock < 0 && ev) begin
                m_hold = g;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, 64'(fire_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < fire_log.size() && i < exp_log.size(); i++)
            check({name, "_order"}, 64'(fire_log[i]), 64'(exp_log[i]));
        fire_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = '0; out_ready = 1'b0; v3 = '0; ready3 = 1'b0;
        for (int i = 0; i < N; i++) begin op[i] = 3'd0; sz[i] = '0; end
        repeat (2) step();
        reset = 1'b0;
        fire_log.delete();

        // Alternating single-beat AccessAcks
        in_valid = 2'b11; out_ready = 1'b1;
        repeat (4) step();
        in_valid = '0;
        exp_log = '{0, 1, 0, 1};
        check_log("t1");

        // 4-beat AccessAckData on in1 with in0 competing
        op[1] = 3'd1; sz[1] = 4'd5; in_valid = 2'b11;
        repeat (6) step();
        in_valid = '0;
        exp_log = '{0, 1, 1, 1, 1, 0};
        check_log("t2");

        // Stall: in0 holds the grant although in1 has round-robin priority
        op[1] = 3'd0; sz[1] = '0; out_ready = 1'b0; in_valid = 2'b01;
        @(negedge clock); check("t3_stall_grant", 64'(o_grant), 64'(0));
        step(); in_valid = 2'b11;
        @(negedge clock); check("t3_stall_grant", 64'(o_grant), 64'(0));
        step();
        @(negedge clock); check("t3_stall_grant", 64'(o_grant), 64'(0));
        step(); out_ready = 1'b1;
        step(); in_valid = 2'b10;
        step(); in_valid = '0;
        exp_log = '{0, 1};
        check_log("t3");

        // 8-beat GrantData on in0 with out_ready toggling
        op[0] = 3'd5; sz[0] = 4'd6; in_valid = 2'b11;
        for (int c = 0; c < 17; c++) begin
            out_ready = (c % 2 == 0);
            if (c == 1) begin @(negedge clock); check("t4_locked", 64'(o_locked), 64'(1)); end
            if (c == 15) begin @(negedge clock); check("t4_unlocked", 64'(o_locked), 64'(0)); end
            step();
        end
        in_valid = '0; op[0] = 3'd0; sz[0] = '0; out_ready = 1'b1;
        exp_log = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        check_log("t4");

        // Reset in the middle of a 4-beat burst
        op[1] = 3'd1; sz[1] = 4'd5; in_valid = 2'b10;
        step(); step();
        reset = 1'b1; in_valid = 2'b11;
        @(negedge clock); check("t5_rst_valid", 64'(o_valid), 64'(0));
        step(); step();
        reset = 1'b0;
        @(negedge clock);
        check("t5_post_locked", 64'(o_locked), 64'(0));
        check("t5_post_grant", 64'(o_grant), 64'(0));
        step();
        in_valid = '0; op[1] = 3'd0; sz[1] = '0;
        exp_log = '{1, 1, 0};
        check_log("t5");

        // Three inputs, all valid, single beats
        v3 = 3'b111; ready3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check("t6_grant3", 64'(o3_grant), 64'(c % 3));
            check("t6_valid3", 64'(o3_valid), 64'(1));
            step();
        end
        v3 = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
